// File: rtl/rv_pipe_pkg.sv
// Shared types for the EX/MEM and MEM/WB pipeline registers and the data-memory sequencer.
// Holds datapath widths, funct3 access-size codes, the sequencer state type and the stage register bundles.
package rv_pipe_pkg;

  localparam int XLEN = 32;
  localparam int RD_W = 5;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic [2:0]      funct3;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] rs2;
  } ex_mem_t;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] wdata;
  } mem_wb_t;

  // The memory port is word addressed; byte position travels separately as lane enables.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~{{(XLEN-2){1'b0}}, 2'b11};
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for sub-word accesses: store replication plus byte enables, and load
// extraction with sign/zero extension. Purely combinational.
module load_store_align
  import rv_pipe_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [XLEN-1:0] load_word_i,
  output logic [XLEN-1:0] wdata_o,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] load_data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = load_word_i[8*addr_lo_i +: 8];
  assign half_v = addr_lo_i[1] ? load_word_i[31:16] : load_word_i[15:0];

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    wdata_o = store_data_i;
    be_o    = 4'hF;
    unique case (funct3_i[1:0])
      2'b00: begin
        wdata_o = {4{store_data_i[7:0]}};
        be_o    = 4'b0001 << addr_lo_i;
      end
      2'b01: begin
        wdata_o = {2{store_data_i[15:0]}};
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    load_data_o = load_word_i;
    unique case (funct3_i)
      F3_B:    load_data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_BU:   load_data_o = {{(XLEN-8){1'b0}}, byte_v};
      F3_H:    load_data_o = {{(XLEN-16){half_v[15]}}, half_v};
      F3_HU:   load_data_o = {{(XLEN-16){1'b0}}, half_v};
      default: ;
    endcase
  end

endmodule

// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers with the IDLE/WAIT data-memory handshake sequencer.
// Define SUBWORD_MEM_EN for byte/halfword accesses; otherwise every access is a full word.
module ex_mem_wb_pipe
  import rv_pipe_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic [RD_W-1:0] ex_rd,
  input  logic            ex_RegWrite,
  input  logic            ex_MemRead,
  input  logic            ex_MemWrite,
  input  logic            ex_MemtoReg,
  input  logic [2:0]      ex_funct3,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            mem_stall,
  output logic            EX_MEM_RegWrite,
  output logic [RD_W-1:0] EX_MEM_rd,
  output logic [XLEN-1:0] EX_MEM_fwd_data,
  output logic            MEM_WB_RegWrite,
  output logic [RD_W-1:0] MEM_WB_rd,
  output logic [XLEN-1:0] MEM_WB_wdata
);

  ex_mem_t    ex_mem_q, ex_mem_d;
  mem_wb_t    mem_wb_q, mem_wb_d;
  mem_state_t state_q, state_d;

  logic            mem_op;
  logic            is_store;
  logic            is_load;
  logic [XLEN-1:0] st_data;
  logic [3:0]      st_be;
  logic [XLEN-1:0] ld_data;

  // A simultaneous read+write request is resolved as a store.
  assign mem_op   = ex_mem_q.valid & (ex_mem_q.mem_read | ex_mem_q.mem_write);
  assign is_store = ex_mem_q.mem_write;
  assign is_load  = ex_mem_q.mem_read & ~ex_mem_q.mem_write;

  assign mem_stall = ((state_q == IDLE) & mem_op & ~dmem_ready)
                   | ((state_q == WAIT) & ~dmem_ready);

  assign dmem_req   = mem_op | (state_q == WAIT);
  assign dmem_we    = dmem_req & is_store;
  assign dmem_addr  = word_align(ex_mem_q.alu);
  assign dmem_wdata = st_data;
  assign dmem_be    = dmem_req ? st_be : 4'h0;

`ifdef SUBWORD_MEM_EN
  load_store_align u_align (
    .funct3_i     (ex_mem_q.funct3),
    .addr_lo_i    (ex_mem_q.alu[1:0]),
    .store_data_i (ex_mem_q.rs2),
    .load_word_i  (dmem_rdata),
    .wdata_o      (st_data),
    .be_o         (st_be),
    .load_data_o  (ld_data)
  );
`else
  assign st_data = ex_mem_q.rs2;
  assign st_be   = 4'hF;
  assign ld_data = dmem_rdata;

  logic unused_subword;
  assign unused_subword = ^{ex_mem_q.funct3, ex_mem_q.alu[1:0]};
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (mem_op && !dmem_ready) state_d = WAIT;
      WAIT:    if (dmem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A stall freezes EX/MEM and pushes a bubble into MEM/WB.
  always_comb begin
    ex_mem_d = ex_mem_q;
    mem_wb_d = '0;
    if (!mem_stall) begin
      ex_mem_d.valid      = ex_valid;
      ex_mem_d.reg_write  = ex_RegWrite;
      ex_mem_d.mem_read   = ex_MemRead;
      ex_mem_d.mem_write  = ex_MemWrite;
      ex_mem_d.mem_to_reg = ex_MemtoReg;
      ex_mem_d.funct3     = ex_funct3;
      ex_mem_d.rd         = ex_rd;
      ex_mem_d.alu        = ex_alu_result;
      ex_mem_d.rs2        = ex_rs2_data;

      mem_wb_d.valid     = ex_mem_q.valid;
      mem_wb_d.reg_write = ex_mem_q.reg_write;
      mem_wb_d.rd        = ex_mem_q.rd;
      mem_wb_d.wdata     = (is_load && ex_mem_q.mem_to_reg) ? ld_data : ex_mem_q.alu;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_mem_q <= '0;
      mem_wb_q <= '0;
      state_q  <= IDLE;
    end else begin
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
      state_q  <= state_d;
    end
  end

  assign EX_MEM_RegWrite = ex_mem_q.valid & ex_mem_q.reg_write;
  assign EX_MEM_rd       = ex_mem_q.rd;
  assign EX_MEM_fwd_data = ex_mem_q.alu;

  assign MEM_WB_RegWrite = mem_wb_q.valid & mem_wb_q.reg_write;
  assign MEM_WB_rd       = mem_wb_q.rd;
  assign MEM_WB_wdata    = mem_wb_q.wdata;

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Scoreboard bench for ex_mem_wb_pipe: directed vectors push expected memory requests and
// writebacks into queues; a negedge monitor pops and compares them as the DUT presents them.
module tb_ex_mem_wb_pipe;
  import rv_pipe_pkg::*;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_rs2_data;
  logic [4:0]  ex_rd;
  logic        ex_RegWrite;
  logic        ex_MemRead;
  logic        ex_MemWrite;
  logic        ex_MemtoReg;
  logic [2:0]  ex_funct3;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic        EX_MEM_RegWrite;
  logic [4:0]  EX_MEM_rd;
  logic [31:0] EX_MEM_fwd_data;
  logic        MEM_WB_RegWrite;
  logic [4:0]  MEM_WB_rd;
  logic [31:0] MEM_WB_wdata;

  ex_mem_wb_pipe dut (
    .clk             (clk),
    .reset           (reset),
    .ex_valid        (ex_valid),
    .ex_alu_result   (ex_alu_result),
    .ex_rs2_data     (ex_rs2_data),
    .ex_rd           (ex_rd),
    .ex_RegWrite     (ex_RegWrite),
    .ex_MemRead      (ex_MemRead),
    .ex_MemWrite     (ex_MemWrite),
    .ex_MemtoReg     (ex_MemtoReg),
    .ex_funct3       (ex_funct3),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_be         (dmem_be),
    .dmem_ready      (dmem_ready),
    .dmem_rdata      (dmem_rdata),
    .mem_stall       (mem_stall),
    .EX_MEM_RegWrite (EX_MEM_RegWrite),
    .EX_MEM_rd       (EX_MEM_rd),
    .EX_MEM_fwd_data (EX_MEM_fwd_data),
    .MEM_WB_RegWrite (MEM_WB_RegWrite),
    .MEM_WB_rd       (MEM_WB_rd),
    .MEM_WB_wdata    (MEM_WB_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  req_t req_q[$];
  wb_t  wb_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   stall_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_req(input logic we, input logic [31:0] addr, wdata, input logic [3:0] be);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wdata; r.be = be;
    req_q.push_back(r);
  endtask

  task automatic push_wb(input logic [4:0] rd, input logic [31:0] data);
    wb_t w;
    w.rd = rd; w.data = data;
    wb_q.push_back(w);
  endtask

  // Monitor: pops the scoreboard whenever a handshake completes or a writeback is presented.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_stall) stall_cnt++;
      if (dmem_req && dmem_ready) begin
        check("req_expected", 32'(req_q.size() > 0), 32'd1);
        if (req_q.size() > 0) begin
          req_t r;
          r = req_q.pop_front();
          check("req_we", 32'(dmem_we), 32'(r.we));
          check("req_addr", dmem_addr, r.addr);
          if (r.we) begin
            check("req_wdata", dmem_wdata, r.wdata);
            check("req_be", 32'(dmem_be), 32'(r.be));
          end
        end
      end
      if (MEM_WB_RegWrite) begin
        check("wb_expected", 32'(wb_q.size() > 0), 32'd1);
        if (wb_q.size() > 0) begin
          wb_t w;
          w = wb_q.pop_front();
          check("wb_rd", 32'(MEM_WB_rd), 32'(w.rd));
          check("wb_data", MEM_WB_wdata, w.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, rs2, input logic [4:0] rd,
                       input logic rw, mr, mw, m2r, input logic [2:0] f3);
    ex_valid = v; ex_alu_result = res; ex_rs2_data = rs2; ex_rd = rd;
    ex_RegWrite = rw; ex_MemRead = mr; ex_MemWrite = mw; ex_MemtoReg = m2r; ex_funct3 = f3;
  endtask

  task automatic bubble();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, F3_W);
  endtask

  // One memory instruction: ready held low for 'waits' cycles, then high for one cycle.
  task automatic mem_access(input logic [31:0] addr, wd, rdat, input logic [4:0] rd,
                            input logic rw, mr, mw, input logic [2:0] f3, input int waits);
    drive(1'b1, addr, wd, rd, rw, mr, mw, mr & ~mw, f3);
    dmem_rdata = rdat;
    dmem_ready = 1'b0;
    tick();
    bubble();
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      check("acc_stall", 32'(mem_stall), 32'd1);
      tick();
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    check("acc_release", 32'(mem_stall), 32'd0);
    tick();
    dmem_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bubble();
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    @(negedge clk);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(mem_stall), 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);
    check("rst_be", 32'(dmem_be), 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_exmem_rw", 32'(EX_MEM_RegWrite), 32'd0);
    check("rst_exmem_rd", 32'(EX_MEM_rd), 32'd0);
    check("rst_exmem_fwd", EX_MEM_fwd_data, 32'd0);
    check("rst_memwb_rw", 32'(MEM_WB_RegWrite), 32'd0);
    check("rst_memwb_rd", 32'(MEM_WB_rd), 32'd0);
    check("rst_memwb_wdata", MEM_WB_wdata, 32'd0);
    tick();

    // ALU op: EX/MEM one edge later, MEM/WB the edge after.
    push_wb(5'd5, 32'h1234);
    drive(1'b1, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, F3_W);
    tick();
    bubble();
    @(negedge clk);
    check("alu_exmem_rd", 32'(EX_MEM_rd), 32'd5);
    check("alu_exmem_rw", 32'(EX_MEM_RegWrite), 32'd1);
    check("alu_exmem_fwd", EX_MEM_fwd_data, 32'h1234);
    check("alu_no_req", 32'(dmem_req), 32'd0);
    tick();
    @(negedge clk);
    check("alu_memwb_rw", 32'(MEM_WB_RegWrite), 32'd1);
    check("alu_memwb_wdata", MEM_WB_wdata, 32'h1234);
    tick();

    // Invalid stage with RegWrite set stays gated.
    drive(1'b0, 32'h55, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, F3_W);
    tick();
    bubble();
    @(negedge clk);
    check("gate_exmem_rw", 32'(EX_MEM_RegWrite), 32'd0);
    tick();
    @(negedge clk);
    check("gate_memwb_rw", 32'(MEM_WB_RegWrite), 32'd0);
    tick();

    // LW 0x100 with ready low for three cycles.
    push_req(1'b0, 32'h100, 32'h0, 4'hF);
    push_wb(5'd10, 32'hCAFE0001);
    stall_cnt = 0;
    drive(1'b1, 32'h100, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, F3_W);
    dmem_rdata = 32'hCAFE0001;
    dmem_ready = 1'b0;
    tick();
    bubble();
    @(negedge clk);
    check("lw_exmem_rw", 32'(EX_MEM_RegWrite), 32'd1);
    check("lw_exmem_fwd", EX_MEM_fwd_data, 32'h100);
    check("lw_stall0", 32'(mem_stall), 32'd1);
    check("lw_req0", 32'(dmem_req), 32'd1);
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("lw_stall_wait", 32'(mem_stall), 32'd1);
      check("lw_bubble", 32'(MEM_WB_RegWrite), 32'd0);
      check("lw_addr_held", dmem_addr, 32'h100);
      tick();
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    check("lw_release", 32'(mem_stall), 32'd0);
    check("lw_bubble3", 32'(MEM_WB_RegWrite), 32'd0);
    tick();
    dmem_ready = 1'b0;
    @(negedge clk);
    check("lw_wdata", MEM_WB_wdata, 32'hCAFE0001);
    check("lw_stall_cycles", 32'(stall_cnt), 32'd3);
    tick();

    // Ready with no request pending is ignored.
    dmem_ready = 1'b1;
    @(negedge clk);
    check("idle_ready_req", 32'(dmem_req), 32'd0);
    check("idle_ready_stall", 32'(mem_stall), 32'd0);
    tick();
    dmem_ready = 1'b0;

    // SW 0x104, ready in the same cycle.
    push_req(1'b1, 32'h104, 32'hDEADBEEF, 4'hF);
    mem_access(32'h104, 32'hDEADBEEF, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, F3_W, 0);
    @(negedge clk);
    check("sw_req_done", 32'(dmem_req), 32'd0);
    check("sw_memwb_rw", 32'(MEM_WB_RegWrite), 32'd0);
    tick();

    // Store then load back-to-back with no idle cycle between requests.
    push_req(1'b1, 32'h200, 32'h11223344, 4'hF);
    push_req(1'b0, 32'h200, 32'h0, 4'hF);
    push_wb(5'd12, 32'h55667788);
    dmem_rdata = 32'h55667788;
    dmem_ready = 1'b1;
    drive(1'b1, 32'h200, 32'h11223344, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, F3_W);
    tick();
    drive(1'b1, 32'h200, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1, F3_W);
    @(negedge clk);
    check("b2b_st_we", 32'(dmem_we), 32'd1);
    tick();
    bubble();
    @(negedge clk);
    check("b2b_ld_req", 32'(dmem_req), 32'd1);
    check("b2b_ld_we", 32'(dmem_we), 32'd0);
    tick();
    dmem_ready = 1'b0;
    @(negedge clk);
    check("b2b_ld_wdata", MEM_WB_wdata, 32'h55667788);
    tick();

    // MemRead and MemWrite both set behaves as a store, here through one WAIT cycle.
    push_req(1'b1, 32'h300, 32'hA5A5A5A5, 4'hF);
    mem_access(32'h300, 32'hA5A5A5A5, 32'h0, 5'd3, 1'b0, 1'b1, 1'b1, F3_W, 1);

`ifdef SUBWORD_MEM_EN
    push_req(1'b0, 32'h100, 32'h0, 4'hF);
    push_wb(5'd13, 32'hFFFFFF80);
    mem_access(32'h103, 32'h0, 32'h80FFFFFF, 5'd13, 1'b1, 1'b1, 1'b0, F3_B, 0);
    push_req(1'b0, 32'h100, 32'h0, 4'hF);
    push_wb(5'd14, 32'h00000080);
    mem_access(32'h103, 32'h0, 32'h80FFFFFF, 5'd14, 1'b1, 1'b1, 1'b0, F3_BU, 0);
    push_req(1'b0, 32'h100, 32'h0, 4'hF);
    push_wb(5'd16, 32'hFFFF8001);
    mem_access(32'h102, 32'h0, 32'h80011234, 5'd16, 1'b1, 1'b1, 1'b0, F3_H, 0);
    push_req(1'b0, 32'h100, 32'h0, 4'hF);
    push_wb(5'd17, 32'h0000F234);
    mem_access(32'h100, 32'h0, 32'h8001F234, 5'd17, 1'b1, 1'b1, 1'b0, F3_HU, 0);
    push_req(1'b1, 32'h100, 32'hABABABAB, 4'b0100);
    mem_access(32'h102, 32'h000000AB, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, F3_B, 0);
    push_req(1'b1, 32'h104, 32'hBEEFBEEF, 4'b1100);
    mem_access(32'h106, 32'h0000BEEF, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, F3_H, 0);
`else
    // Word-only build: funct3 has no effect on data or enables.
    push_req(1'b0, 32'h100, 32'h0, 4'hF);
    push_wb(5'd13, 32'h80FFFFFF);
    mem_access(32'h103, 32'h0, 32'h80FFFFFF, 5'd13, 1'b1, 1'b1, 1'b0, F3_B, 0);
    push_req(1'b1, 32'h100, 32'h000000AB, 4'hF);
    mem_access(32'h102, 32'h000000AB, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, F3_B, 0);
`endif

    // Reset while WAIT abandons the access.
    drive(1'b1, 32'h400, 32'h0, 5'd15, 1'b1, 1'b1, 1'b0, 1'b1, F3_W);
    dmem_ready = 1'b0;
    tick();
    bubble();
    @(negedge clk);
    check("rw_stall_idle", 32'(mem_stall), 32'd1);
    tick();
    @(negedge clk);
    check("rw_stall_wait", 32'(mem_stall), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("rw_req", 32'(dmem_req), 32'd0);
    check("rw_stall", 32'(mem_stall), 32'd0);
    check("rw_exmem_rw", 32'(EX_MEM_RegWrite), 32'd0);
    check("rw_memwb_rw", 32'(MEM_WB_RegWrite), 32'd0);
    tick();
    reset = 1'b0;

    // Pipeline resumes normally after the reset.
    push_wb(5'd9, 32'h77);
    drive(1'b1, 32'h77, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, F3_W);
    tick();
    bubble();
    tick();
    @(negedge clk);
    check("post_rst_wdata", MEM_WB_wdata, 32'h77);
    tick();

    repeat (3) tick();
    check("req_q_drained", 32'(req_q.size()), 32'd0);
    check("wb_q_drained", 32'(wb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
